// File: rtl/jtag_tap_ctrl_if.sv
// rtl/jtag_tap_ctrl_if.sv - JTAG pin bundle between a scan master and the TAP slave
interface jtag_tap_ctrl_if;
  logic tms;
  logic tdi;
  logic tdo;
  logic tdo_en;

  modport master (output tms, output tdi, input tdo, input tdo_en);
  modport slave  (input tms, input tdi, output tdo, output tdo_en);
endinterface

// File: rtl/jtag_tap_ctrl.sv
// rtl/jtag_tap_ctrl.sv - 1149.1-style TAP slave with IR, BYPASS, optional IDCODE and user data registers
// Optional IDCODE register enabled by defining JTAG_TAP_IDCODE_EN; otherwise opcode 1 and reset select BYPASS.
module jtag_tap_ctrl #(
  parameter int          IR_WIDTH   = 4,
  parameter int          DR_WIDTH   = 32,
  parameter int          NUM_UDR    = 2,
  parameter logic [31:0] IDCODE_VAL = 32'h1234_5001
) (
  input  logic                         tck,
  input  logic                         trst,
  jtag_tap_ctrl_if.slave               jtag,
  output logic [IR_WIDTH-1:0]          ir_q,
  output logic [3:0]                   tap_state,
  input  logic [NUM_UDR*DR_WIDTH-1:0]  udr_capture_data,
  output logic [NUM_UDR*DR_WIDTH-1:0]  udr_update_data,
  output logic [NUM_UDR-1:0]           udr_update_pulse
);

  typedef enum logic [3:0] {
    TLR   = 4'hF, RTI   = 4'hC,
    SELDR = 4'h7, CAPDR = 4'h6, SHDR  = 4'h2, EX1DR = 4'h1,
    PDR   = 4'h3, EX2DR = 4'h0, UPDDR = 4'h5,
    SELIR = 4'h4, CAPIR = 4'hE, SHIR  = 4'hA, EX1IR = 4'h9,
    PIR   = 4'hB, EX2IR = 4'h8, UPDIR = 4'hD
  } tap_state_e;

`ifdef JTAG_TAP_IDCODE_EN
  localparam logic [IR_WIDTH-1:0] IR_RESET = IR_WIDTH'(1);
`else
  localparam logic [IR_WIDTH-1:0] IR_RESET = '1;
`endif

  if (IR_WIDTH < 2) begin : g_chk_ir_width
    $error("jtag_tap_ctrl: IR_WIDTH must be >= 2");
  end
  if (DR_WIDTH < 1) begin : g_chk_dr_width
    $error("jtag_tap_ctrl: DR_WIDTH must be >= 1");
  end
  if (NUM_UDR + 2 > (1 << IR_WIDTH) - 1) begin : g_chk_num_udr
    $error("jtag_tap_ctrl: too many user data registers for IR_WIDTH");
  end
  if (IDCODE_VAL[0] != 1'b1) begin : g_chk_idcode
    $error("jtag_tap_ctrl: IDCODE_VAL bit 0 must be 1");
  end

  tap_state_e                              state_q, state_d;
  logic [IR_WIDTH-1:0]                     ir_d;
  logic [IR_WIDTH-1:0]                     ir_sr_q, ir_sr_d;
  logic                                    byp_q, byp_d;
  logic [NUM_UDR-1:0][DR_WIDTH-1:0]        udr_sr_q, udr_sr_d;
  logic [NUM_UDR-1:0][DR_WIDTH-1:0]        upd_q, upd_d;
  logic [NUM_UDR-1:0]                      pulse_q, pulse_d;
  logic                                    tdo_q, tdo_d;
  logic                                    tdo_en_q, tdo_en_d;
  logic                                    sel_idcode;
  logic [NUM_UDR-1:0]                      sel_udr;
  logic                                    dr_tdo;
`ifdef JTAG_TAP_IDCODE_EN
  logic [31:0]                             id_sr_q, id_sr_d;
`endif

  always_ff @(posedge tck) begin
    if (trst) begin
      state_q  <= TLR;
      ir_q     <= IR_RESET;
      ir_sr_q  <= '0;
      byp_q    <= 1'b0;
      udr_sr_q <= '0;
      upd_q    <= '0;
      pulse_q  <= '0;
      tdo_q    <= 1'b0;
      tdo_en_q <= 1'b0;
`ifdef JTAG_TAP_IDCODE_EN
      id_sr_q  <= '0;
`endif
    end else begin
      state_q  <= state_d;
      ir_q     <= ir_d;
      ir_sr_q  <= ir_sr_d;
      byp_q    <= byp_d;
      udr_sr_q <= udr_sr_d;
      upd_q    <= upd_d;
      pulse_q  <= pulse_d;
      tdo_q    <= tdo_d;
      tdo_en_q <= tdo_en_d;
`ifdef JTAG_TAP_IDCODE_EN
      id_sr_q  <= id_sr_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      TLR:     state_d = jtag.tms ? TLR   : RTI;
      RTI:     state_d = jtag.tms ? SELDR : RTI;
      SELDR:   state_d = jtag.tms ? SELIR : CAPDR;
      CAPDR:   state_d = jtag.tms ? EX1DR : SHDR;
      SHDR:    state_d = jtag.tms ? EX1DR : SHDR;
      EX1DR:   state_d = jtag.tms ? UPDDR : PDR;
      PDR:     state_d = jtag.tms ? EX2DR : PDR;
      EX2DR:   state_d = jtag.tms ? UPDDR : SHDR;
      UPDDR:   state_d = jtag.tms ? SELDR : RTI;
      SELIR:   state_d = jtag.tms ? TLR   : CAPIR;
      CAPIR:   state_d = jtag.tms ? EX1IR : SHIR;
      SHIR:    state_d = jtag.tms ? EX1IR : SHIR;
      EX1IR:   state_d = jtag.tms ? UPDIR : PIR;
      PIR:     state_d = jtag.tms ? EX2IR : PIR;
      EX2IR:   state_d = jtag.tms ? UPDIR : SHIR;
      UPDIR:   state_d = jtag.tms ? SELDR : RTI;
      default: state_d = TLR;
    endcase
  end

  // Anything not decoded as IDCODE or a UDR falls through to the bypass path.
  always_comb begin
    sel_idcode = 1'b0;
    sel_udr    = '0;
`ifdef JTAG_TAP_IDCODE_EN
    sel_idcode = (ir_q == IR_WIDTH'(1));
`endif
    for (int k = 0; k < NUM_UDR; k++) begin
      sel_udr[k] = (ir_q == IR_WIDTH'(k + 2));
    end
  end

  always_comb begin
    dr_tdo = byp_q;
`ifdef JTAG_TAP_IDCODE_EN
    if (sel_idcode) dr_tdo = id_sr_q[0];
`endif
    for (int k = 0; k < NUM_UDR; k++) begin
      if (sel_udr[k]) dr_tdo = udr_sr_q[k][0];
    end
  end

  always_comb begin
    ir_d     = ir_q;
    ir_sr_d  = ir_sr_q;
    byp_d    = byp_q;
    udr_sr_d = udr_sr_q;
    upd_d    = upd_q;
    pulse_d  = '0;
    tdo_d    = tdo_q;
    tdo_en_d = (state_q == SHIR) || (state_q == SHDR);
`ifdef JTAG_TAP_IDCODE_EN
    id_sr_d  = id_sr_q;
`endif
    case (state_q)
      CAPIR: ir_sr_d = IR_WIDTH'(1);
      SHIR: begin
        tdo_d                 = ir_sr_q[0];
        ir_sr_d               = ir_sr_q >> 1;
        ir_sr_d[IR_WIDTH-1]   = jtag.tdi;
      end
      UPDIR: ir_d = ir_sr_q;
      CAPDR: begin
        byp_d = 1'b0;
`ifdef JTAG_TAP_IDCODE_EN
        if (sel_idcode) id_sr_d = IDCODE_VAL;
`endif
        for (int k = 0; k < NUM_UDR; k++) begin
          if (sel_udr[k]) udr_sr_d[k] = udr_capture_data[k*DR_WIDTH +: DR_WIDTH];
        end
      end
      SHDR: begin
        tdo_d = dr_tdo;
        byp_d = jtag.tdi;
`ifdef JTAG_TAP_IDCODE_EN
        if (sel_idcode) begin
          id_sr_d     = id_sr_q >> 1;
          id_sr_d[31] = jtag.tdi;
        end
`endif
        for (int k = 0; k < NUM_UDR; k++) begin
          if (sel_udr[k]) begin
            udr_sr_d[k]             = udr_sr_q[k] >> 1;
            udr_sr_d[k][DR_WIDTH-1] = jtag.tdi;
          end
        end
      end
      UPDDR: begin
        for (int k = 0; k < NUM_UDR; k++) begin
          if (sel_udr[k]) begin
            upd_d[k]   = udr_sr_q[k];
            pulse_d[k] = 1'b1;
          end
        end
      end
      default: ;
    endcase
    if (state_d == TLR) ir_d = IR_RESET;
  end

  assign jtag.tdo         = tdo_q;
  assign jtag.tdo_en      = tdo_en_q;
  assign tap_state        = state_q;
  assign udr_update_data  = upd_q;
  assign udr_update_pulse = pulse_q;

endmodule

// File: tb/tb_jtag_tap_ctrl.sv
// tb/tb_jtag_tap_ctrl.sv - directed and random scan traffic against a behavioural TAP model
module tb_jtag_tap_ctrl;
  localparam int IRW = 4;
  localparam int DRW = 32;
  localparam int NU  = 2;
  localparam logic [31:0] IDV = 32'h1234_5001;
`ifdef JTAG_TAP_IDCODE_EN
  localparam bit ID_EN = 1'b1;
  localparam logic [3:0] IR_RST = 4'h1;
`else
  localparam bit ID_EN = 1'b0;
  localparam logic [3:0] IR_RST = 4'hF;
`endif
  localparam int S_TLR = 15, S_CAPDR = 6, S_SHDR = 2, S_UPDDR = 5;
  localparam int S_CAPIR = 14, S_SHIR = 10, S_UPDIR = 13;

  logic        tck = 1'b0;
  logic        trst = 1'b1;
  logic [3:0]  ir_q;
  logic [3:0]  tap_state;
  logic [63:0] cap_data = '0;
  logic [63:0] upd_data;
  logic [1:0]  pulse;

  jtag_tap_ctrl_if jif ();

  jtag_tap_ctrl #(.IR_WIDTH(IRW), .DR_WIDTH(DRW), .NUM_UDR(NU), .IDCODE_VAL(IDV)) dut (
    .tck(tck), .trst(trst), .jtag(jif), .ir_q(ir_q), .tap_state(tap_state),
    .udr_capture_data(cap_data), .udr_update_data(upd_data), .udr_update_pulse(pulse)
  );

  always #5 tck = ~tck;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Next-state tables indexed by the state code, one per tms value.
  int tbl0[16] = '{2, 3, 2, 3, 14, 12, 2, 6, 10, 11, 10, 11, 12, 12, 10, 12};
  int tbl1[16] = '{5, 5, 1, 0, 15, 7, 1, 4, 13, 13, 9, 8, 7, 7, 9, 15};

  int          m_state;
  logic [3:0]  m_ir, m_ir_sr;
  logic        m_tdo, m_en, m_byp;
  logic [31:0] m_id;
  logic [31:0] m_udr[2];
  logic [63:0] m_upd;
  logic [1:0]  m_pulse;

  // -2 = IDCODE, -1 = BYPASS, k >= 0 = user register k
  function automatic int sel_of(input logic [3:0] ir);
    if (ID_EN && ir == 4'd1) return -2;
    if (ir >= 4'd2 && int'(ir) < 2 + NU) return int'(ir) - 2;
    return -1;
  endfunction

  task automatic model_edge(input logic t_ms, input logic t_di, input logic t_rst);
    int sel;
    int nxt;
    if (t_rst) begin
      m_state = S_TLR; m_ir = IR_RST; m_ir_sr = '0; m_tdo = 0; m_en = 0; m_byp = 0;
      m_id = '0; m_udr[0] = '0; m_udr[1] = '0; m_upd = '0; m_pulse = '0;
      return;
    end
    sel     = sel_of(m_ir);
    nxt     = t_ms ? tbl1[m_state] : tbl0[m_state];
    m_pulse = '0;
    m_en    = (m_state == S_SHIR) || (m_state == S_SHDR);
    case (m_state)
      S_CAPIR: m_ir_sr = 4'b0001;
      S_SHIR: begin m_tdo = m_ir_sr[0]; m_ir_sr = {t_di, m_ir_sr[3:1]}; end
      S_UPDIR: m_ir = m_ir_sr;
      S_CAPDR: begin
        if (sel == -2) m_id = IDV;
        else if (sel >= 0) m_udr[sel] = cap_data[sel*32 +: 32];
        else m_byp = 1'b0;
      end
      S_SHDR: begin
        if (sel == -2) begin m_tdo = m_id[0]; m_id = {t_di, m_id[31:1]}; end
        else if (sel >= 0) begin m_tdo = m_udr[sel][0]; m_udr[sel] = {t_di, m_udr[sel][31:1]}; end
        else begin m_tdo = m_byp; m_byp = t_di; end
      end
      S_UPDDR: if (sel >= 0) begin m_upd[sel*32 +: 32] = m_udr[sel]; m_pulse[sel] = 1'b1; end
      default: ;
    endcase
    m_state = nxt;
    if (nxt == S_TLR) m_ir = IR_RST;
  endtask

  task automatic step(input logic t_ms, input logic t_di = 1'b0, input logic t_rst = 1'b0);
    jif.tms = t_ms;
    jif.tdi = t_di;
    trst    = t_rst;
    @(posedge tck);
    model_edge(t_ms, t_di, t_rst);
    #1;
    check("state", tap_state, m_state[3:0]);
    check("ir_q", ir_q, m_ir);
    check("tdo_en", jif.tdo_en, m_en);
    check("tdo", jif.tdo, m_tdo);
    check("upd_data", upd_data, m_upd);
    check("upd_pulse", pulse, m_pulse);
  endtask

  // Starts and ends in Run-Test/Idle.
  task automatic load_ir(input logic [3:0] val, output logic [3:0] shout);
    step(1); step(1); step(0); step(0);
    for (int i = 0; i < IRW; i++) begin
      step(i == IRW - 1, val[i]);
      shout[i] = jif.tdo;
    end
    step(1); step(0);
  endtask

  // Starts and ends in Run-Test/Idle; optional pause after bit pause_at-1.
  task automatic scan_dr(input int n, input logic [63:0] din, input int pause_at,
                         output logic [63:0] dout, output logic [1:0] pls);
    dout = '0;
    step(1); step(0); step(0);
    for (int i = 0; i < n; i++) begin
      step((i == n - 1) || (i == pause_at - 1), din[i]);
      dout[i] = jif.tdo;
      if (i == n - 1) check("tdo_en_last_shift", jif.tdo_en, 1'b1);
      if (i == pause_at - 1 && i != n - 1) begin
        step(0); step(0); step(1); step(0);
      end
    end
    step(1); step(0);
    pls = pulse;
  endtask

  logic [3:0]  sh;
  logic [63:0] din, dout, xcap;
  logic [1:0]  pls;
  logic        walk_tms[19] = '{0,1,0,0,1,0,1,1,1,1,0,0,1,0,1,1,1,1,1};
  int          walk_exp[19] = '{12,7,6,2,1,3,0,5,7,4,14,10,9,11,8,13,7,4,15};

  initial begin
    jif.tms = 1'b1;
    jif.tdi = 1'b0;
    step(1, 0, 1);
    check("rst_state", tap_state, 4'hF);
    check("rst_ir", ir_q, IR_RST);
    check("rst_tdo_en", jif.tdo_en, 1'b0);
    check("rst_upd", upd_data, 64'h0);
    for (int i = 0; i < 5; i++) step(1);
    check("tlr_state", tap_state, 4'hF);
    check("tlr_ir", ir_q, IR_RST);
    step(0);

    din = {32'h0, $urandom};
    scan_dr(32, din, 0, dout, pls);
    check("reset_dr_scan", dout[31:0], ID_EN ? IDV : {din[30:0], 1'b0});

    load_ir(4'hF, sh);
    check("ir_capture_out", sh, 4'b0001);
    check("ir_bypass", ir_q, 4'hF);
    scan_dr(9, 64'h0A5, 0, dout, pls);
    check("bypass_delay", dout[8:0], 9'h14A);
    check("bypass_no_pulse", pls, 2'b00);

    cap_data = {32'h0BAD_F00D, 32'hDEAD_BEEF};
    load_ir(4'h2, sh);
    scan_dr(32, 64'hC3, 0, dout, pls);
    check("udr0_capture", dout[31:0], 32'hDEAD_BEEF);
    check("udr0_pulse", pls, 2'b01);
    check("udr0_slice0", upd_data[31:0], 32'h0000_00C3);
    check("udr0_slice1", upd_data[63:32], 32'h0);
    step(0);
    check("udr0_pulse_once", pulse, 2'b00);

    load_ir(4'h7, sh);
    din = {48'h0, 16'($urandom)};
    scan_dr(16, din, 0, dout, pls);
    check("unknown_bypass", dout[15:0], {din[14:0], 1'b0});
    check("unknown_no_pulse", pls, 2'b00);

    load_ir(4'h3, sh);
    step(1); step(0); step(0);
    for (int i = 0; i < 10; i++) step(0, 1'($urandom));
    step(0, 0, 1);
    check("trst_state", tap_state, 4'hF);
    check("trst_pulse", pulse, 2'b00);
    check("trst_upd", upd_data, 64'h0);
    check("trst_tdo_en", jif.tdo_en, 1'b0);
    check("trst_ir", ir_q, IR_RST);

    for (int i = 0; i < 19; i++) begin
      step(walk_tms[i]);
      check("walk", tap_state, walk_exp[i][3:0]);
    end

    step(0);
    xcap = {$urandom, $urandom};
    cap_data = xcap;
    load_ir(4'h3, sh);
    din = {32'h0, $urandom};
    scan_dr(32, din, 16, dout, pls);
    check("pause_capture", dout[31:0], xcap[63:32]);
    check("pause_pulse", pls, 2'b10);
    check("pause_update", upd_data[63:32], din[31:0]);

    for (int r = 0; r < 30; r++) begin
      cap_data = {$urandom, $urandom};
      load_ir(4'($urandom), sh);
      check("rand_ir_capture", sh, 4'b0001);
      scan_dr($urandom_range(1, 40), {$urandom, $urandom}, $urandom_range(0, 40), dout, pls);
    end

    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 49) == 0) cap_data = {$urandom, $urandom};
      step($urandom_range(0, 99) < 35, 1'($urandom), $urandom_range(0, 299) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/jtag_tap_ctrl.md
Name: jtag_tap_ctrl

Overview:
- Parametrised IEEE 1149.1-style TAP slave: 16-state TAP FSM, instruction register of configurable width, BYPASS, IDCODE and NUM_UDR user data registers of configurable width.
- Sits on the slave side of the JTAG pin bundle (tdi/tms in, tdo out).
- Bridges serial scan to parallel capture/update buses feeding on-chip DFT control registers.

Parameters:
- IR_WIDTH, 4: instruction register width; must be >= 2.
- DR_WIDTH, 32: width of each user data register; must be >= 1.
- NUM_UDR, 2: number of user data registers; NUM_UDR+2 <= 2^IR_WIDTH-1.
- IDCODE_VAL, 32'h1234_5001: IDCODE register value; bit 0 must be 1.

Ports:
- tck, in, 1: the single clock; all logic is on the rising edge.
- trst, in, 1: synchronous active-high reset.
- tms, in, 1: mode select, sampled on the rising edge of tck.
- tdi, in, 1: serial data in.
- tdo, out, 1: serial data out, registered.
- tdo_en, out, 1: tdo valid / pad output enable, registered.
- ir_q, out, IR_WIDTH: active instruction.
- tap_state, out, 4: current FSM state encoding.
- udr_capture_data, in, NUM_UDR*DR_WIDTH: parallel capture values; UDR k is bits [k*DR_WIDTH +: DR_WIDTH].
- udr_update_data, out, NUM_UDR*DR_WIDTH: parallel update registers, same slicing as capture.
- udr_update_pulse, out, NUM_UDR: one-cycle strobe per UDR on update.

Behaviour:
- State encodings:
  - TLR=F, RTI=C, SELDR=7, CAPDR=6, SHDR=2, EX1DR=1, PDR=3, EX2DR=0, UPDDR=5
  - SELIR=4, CAPIR=E, SHIR=A, EX1IR=9, PIR=B, EX2IR=8, UPDIR=D
- Transitions are standard 1149.1 on tms each rising tck edge. From any state, five consecutive tms=1 reach TLR.
- Reset (trst=1 at an edge): state=TLR, ir_q=IDCODE opcode, tdo=0, tdo_en=0, udr_update_data=0, udr_update_pulse=0, all shift registers 0.
  - Reset mid-shift discards shift contents; no update pulse is generated.
- Entering TLR via tms has the same effect on ir_q (IDCODE). udr_update_data is retained.
- Opcode decode:
  - 1 = IDCODE.
  - 2+k = UDR k, for k = 0..NUM_UDR-1.
  - all-ones = BYPASS.
  - Any other value, including 0, selects BYPASS.
- CAPIR: IR shift register <= {0..0,2'b01}.
- SHIR:
  - shift right; tdi enters the MSB.
  - tdo <= shift reg bit0, taken before the shift.
- UPDIR: ir_q <= IR shift register. ir_q changes only in UPDIR, TLR or reset.
- CAPDR, per selected register:
  - BYPASS reg <= 0.
  - IDCODE shift <= IDCODE_VAL.
  - UDR k shift <= capture slice k.
- SHDR:
  - The selected register shifts right, tdi into its MSB; tdo <= its bit0 before the shift.
  - BYPASS is a 1-bit register, so shifted data is delayed exactly one cycle.
- UPDDR with UDR k selected:
  - udr_update_data slice k <= UDR k shift register.
  - udr_update_pulse[k]=1 for exactly the next cycle.
  - No other slice or pulse changes.
- UPDDR with IDCODE or BYPASS selected: no outputs change.
- tdo_en <= 1 on the edge where the current state is SHIR or SHDR, else 0. tdo/tdo_en therefore lag the shift state by one cycle.
  - When tdo_en=0, tdo holds its last value.
- Pause/Exit states hold the shift register unchanged.
- Shift length is unlimited. Bits shifted past the register width fall out to tdo and are lost.
- tap_state mirrors the state register; it is not combinational from tms.

Optional Feature:
- Macro: JTAG_TAP_IDCODE_EN.
- Defined: IDCODE register exists as described, and reset/TLR load ir_q with opcode 1.
- Undefined:
  - No IDCODE register.
  - Opcode 1 decodes as BYPASS.
  - Reset/TLR load ir_q with all-ones (BYPASS).
  - In Shift-DR after reset the 1-bit bypass path is observed instead of IDCODE_VAL.

Test Plan:
- Reset then 5x tms=1: tap_state=F, ir_q=4'h1. Go to SHDR and shift 32 bits: tdo sequence is 32'h1234_5001 LSB first (first bit 1), tdo_en=1 during the shift cycles +1.
- Load IR 4'hF: IR shift-out during SHIR is 4'b0001 LSB first. Then shift 8 bits 8'hA5 in SHDR: tdo is 0 followed by 8'hA5 delayed one bit.
- IR=4'h2 (UDR0), capture slice0=32'hDEAD_BEEF, shift in 32'h0000_00C3: tdo returns 32'hDEAD_BEEF. After UPDDR, slice0=32'h0000_00C3 and udr_update_pulse=2'b01 for one cycle; slice1 is unchanged.
- Unknown opcode 4'h7: DR path behaves as 1-bit bypass; UPDDR produces no pulse.
- Assert trst while in SHDR mid-transfer of UDR1: next state is TLR, no pulse, udr_update_data=0, tdo_en=0.
- Walk all 16 states via a tms pattern and check the tap_state encoding at each step. Exercise PDR→EX2DR→SHDR and verify shift data continuity across the pause.
